// File: rtl/trdb_pkg.sv
// Shared packet-type codes and length helpers for the trace debugger packet path.
package trdb_pkg;

  typedef enum logic [1:0] {
    W_LOST     = 2'h0,
    W_SOFTWARE = 2'h1,
    W_TRACE    = 2'h2,
    W_TIME     = 2'h3
  } trdb_packet_type_e;

  localparam int unsigned LOSTLEN      = 16;
  localparam int unsigned LOST_PKT_LEN = 2 + LOSTLEN;
  localparam int unsigned SW_HDR_LEN   = 2;
  localparam int unsigned TIME_HDR_LEN = 3;

  // A single software channel still carries a one-bit channel field.
  function automatic int unsigned sw_ch_width(input int unsigned nsw);
    return (nsw > 1) ? $clog2(nsw) : 1;
  endfunction

  function automatic int unsigned sw_pkt_len(input int unsigned nsw, input int unsigned xlen);
    return SW_HDR_LEN + sw_ch_width(nsw) + xlen;
  endfunction

  function automatic int unsigned time_pkt_len(input int unsigned twidth);
    return TIME_HDR_LEN + twidth;
  endfunction

endpackage

// File: rtl/trdb_packet_fifo.sv
// Registered FIFO for encoded packets; accepts a push on full when a pop happens that cycle.
module trdb_packet_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // The head is masked so unwritten storage never reaches the output.
  assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage has no reset; only the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/trdb_packet_emitter_mc.sv
// Arbitrates trace, loss-report, software and timer sources into one buffered packet stream.
module trdb_packet_emitter_mc
  import trdb_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned NSW              = 2,
  parameter int unsigned TIMER_WIDTH      = 40,
  parameter int unsigned TIMER_DIFF_WIDTH = 16,
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned PACKET_LEN       = 128
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          trace_valid_i,
  input  logic [PACKET_LEN-1:0]         trace_bits_i,
  input  logic [6:0]                    trace_len_i,
  input  logic [NSW-1:0]                sw_valid_i,
  input  logic [NSW-1:0][XLEN-1:0]      sw_word_i,
  output logic [NSW-1:0]                sw_grant_o,
  input  logic                          tu_valid_i,
  input  logic [TIMER_WIDTH-1:0]        tu_time_i,
  input  logic                          tu_fulltime_i,
  output logic                          tu_grant_o,
  output logic [PACKET_LEN-1:0]         packet_bits_o,
  output logic [6:0]                    packet_len_o,
  output logic                          packet_valid_o,
  input  logic                          packet_ready_i,
  output logic                          lost_o
);

  localparam int unsigned CHW           = sw_ch_width(NSW);
  localparam logic [6:0]  SW_LEN        = 7'(sw_pkt_len(NSW, XLEN));
  localparam logic [6:0]  TIME_FULL_LEN = 7'(time_pkt_len(TIMER_WIDTH));
  localparam logic [6:0]  TIME_DIFF_LEN = 7'(time_pkt_len(TIMER_DIFF_WIDTH));
  localparam logic [6:0]  LOST_LEN      = 7'(LOST_PKT_LEN);

  logic [LOSTLEN-1:0]     lost_cnt_q;
  logic [CHW-1:0]         rr_ptr_q, sw_win;
  logic                   sw_any;
  logic                   fifo_full, fifo_empty, pop, free;
  logic                   trace_wr, lost_wr, sw_wr, tu_wr, drop;
  logic [PACKET_LEN-1:0]  wr_bits;
  logic [6:0]             wr_len;
  int unsigned            idx;

  assign pop      = packet_valid_o && packet_ready_i;
  assign free     = !fifo_full || pop;
  assign trace_wr = trace_valid_i && (lost_cnt_q == '0) && free;
  assign drop     = trace_valid_i && !trace_wr;
  assign lost_wr  = !trace_valid_i && (lost_cnt_q != '0) && free;
  assign sw_wr    = !trace_wr && !lost_wr && free && sw_any;
  assign tu_wr    = !trace_wr && !lost_wr && !sw_wr && free && tu_valid_i;

  assign lost_o     = drop;
  assign tu_grant_o = tu_wr;
  assign sw_grant_o = sw_wr ? (NSW'(1) << sw_win) : '0;

  // Scan downward so the requester nearest rr_ptr_q is the last (winning) assignment.
  always_comb begin
    sw_any = 1'b0;
    sw_win = '0;
    idx    = 0;
    for (int i = NSW - 1; i >= 0; i--) begin
      idx = (int'(rr_ptr_q) + i) % NSW;
      if (sw_valid_i[idx]) begin
        sw_any = 1'b1;
        sw_win = CHW'(idx);
      end
    end
  end

  always_comb begin
    wr_bits = '0;
    wr_len  = '0;
    if (trace_wr) begin
      wr_bits = trace_bits_i;
      wr_len  = trace_len_i;
    end else if (lost_wr) begin
      wr_bits[1:0]         = W_LOST;
      wr_bits[2+:LOSTLEN]  = lost_cnt_q;
      wr_len               = LOST_LEN;
    end else if (sw_wr) begin
      wr_bits[1:0]         = W_SOFTWARE;
      wr_bits[2+:CHW]      = sw_win;
      wr_bits[2+CHW+:XLEN] = sw_word_i[sw_win];
      wr_len               = SW_LEN;
    end else if (tu_wr) begin
      wr_bits[1:0] = W_TIME;
      wr_bits[2]   = tu_fulltime_i;
      if (tu_fulltime_i) begin
        wr_bits[3+:TIMER_WIDTH] = tu_time_i;
        wr_len                  = TIME_FULL_LEN;
      end else begin
        wr_bits[3+:TIMER_DIFF_WIDTH] = tu_time_i[TIMER_DIFF_WIDTH-1:0];
        wr_len                       = TIME_DIFF_LEN;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      if (drop) begin
        if (lost_cnt_q != '1) lost_cnt_q <= lost_cnt_q + 1'b1;
      end else if (lost_wr) begin
        lost_cnt_q <= '0;
      end
      if (sw_wr) rr_ptr_q <= (sw_win == CHW'(NSW - 1)) ? '0 : sw_win + 1'b1;
    end
  end

  trdb_packet_fifo #(
    .WIDTH(PACKET_LEN + 7),
    .DEPTH(DEPTH)
  ) i_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (trace_wr || lost_wr || sw_wr || tu_wr),
    .data_i ({wr_len, wr_bits}),
    .pop_i  (pop),
    .data_o ({packet_len_o, packet_bits_o}),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign packet_valid_o = !fifo_empty;

endmodule

// File: tb/tb_trdb_packet_emitter_mc.sv
// Directed bench for trdb_packet_emitter_mc with hand-computed packet encodings.
module tb_trdb_packet_emitter_mc;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             trace_valid_i;
  logic [127:0]     trace_bits_i;
  logic [6:0]       trace_len_i;
  logic [1:0]       sw_valid_i;
  logic [1:0][31:0] sw_word_i;
  logic [1:0]       sw_grant_o;
  logic             tu_valid_i;
  logic [39:0]      tu_time_i;
  logic             tu_fulltime_i;
  logic             tu_grant_o;
  logic [127:0]     packet_bits_o;
  logic [6:0]       packet_len_o;
  logic             packet_valid_o;
  logic             packet_ready_i;
  logic             lost_o;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses;

  always #5 clk_i = ~clk_i;

  trdb_packet_emitter_mc dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .trace_valid_i (trace_valid_i),
    .trace_bits_i  (trace_bits_i),
    .trace_len_i   (trace_len_i),
    .sw_valid_i    (sw_valid_i),
    .sw_word_i     (sw_word_i),
    .sw_grant_o    (sw_grant_o),
    .tu_valid_i    (tu_valid_i),
    .tu_time_i     (tu_time_i),
    .tu_fulltime_i (tu_fulltime_i),
    .tu_grant_o    (tu_grant_o),
    .packet_bits_o (packet_bits_o),
    .packet_len_o  (packet_len_o),
    .packet_valid_o(packet_valid_o),
    .packet_ready_i(packet_ready_i),
    .lost_o        (lost_o)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Trace packet k: tag in bits [15:8], type code 2'b10.
  function automatic logic [127:0] trace_pkt(input int k);
    return (128'(k + 1) << 8) | 128'h2;
  endfunction

  function automatic logic [127:0] sw_pkt(input int ch, input logic [31:0] word);
    return (128'(word) << 3) | (128'(ch) << 2) | 128'h1;
  endfunction

  task automatic send_trace(input int k);
    trace_valid_i = 1'b1;
    trace_bits_i  = trace_pkt(k);
    trace_len_i   = 7'd10;
  endtask

  initial begin
    rst_ni         = 1'b0;
    trace_valid_i  = 1'b0;
    trace_bits_i   = '0;
    trace_len_i    = '0;
    sw_valid_i     = '0;
    sw_word_i      = '0;
    tu_valid_i     = 1'b0;
    tu_time_i      = '0;
    tu_fulltime_i  = 1'b0;
    packet_ready_i = 1'b0;

    #12;
    check("rst_valid", 128'(packet_valid_o), 128'h0);
    check("rst_bits", packet_bits_o, 128'h0);
    check("rst_len", 128'(packet_len_o), 128'h0);
    check("rst_grants", {125'h0, sw_grant_o, tu_grant_o}, 128'h0);
    check("rst_lost", 128'(lost_o), 128'h0);
    #10 rst_ni = 1'b1;
    tick();

    // Single trace packet passes through with one cycle latency.
    packet_ready_i = 1'b1;
    trace_valid_i  = 1'b1;
    trace_bits_i   = 128'h0000_1234_5678_9ABE;
    trace_len_i    = 7'd45;
    #1 check("t1_nolost", 128'(lost_o), 128'h0);
    tick();
    trace_valid_i = 1'b0;
    check("t1_valid", 128'(packet_valid_o), 128'h1);
    check("t1_bits", packet_bits_o, 128'h0000_1234_5678_9ABE);
    check("t1_len", 128'(packet_len_o), 128'd45);
    tick();
    check("t1_drained", 128'(packet_valid_o), 128'h0);

    // Six traces into a stalled 4-deep FIFO: the last two are dropped.
    packet_ready_i = 1'b0;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      send_trace(i);
      #1 check($sformatf("t2_lost%0d", i), 128'(lost_o), 128'((i >= 4) ? 1 : 0));
      tick();
    end
    trace_valid_i = 1'b0;
    check("t2_stall_head", packet_bits_o, trace_pkt(0));
    packet_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_head%0d", i), packet_bits_o, trace_pkt(i));
      tick();
    end
    check("t2_loss_bits", packet_bits_o, 128'h8);
    check("t2_loss_len", 128'(packet_len_o), 128'd18);
    tick();
    check("t2_empty", 128'(packet_valid_o), 128'h0);

    // Full FIFO plus pop plus trace in the same cycle: accepted, no drop.
    packet_ready_i = 1'b0;
    for (int i = 10; i < 14; i++) begin
      send_trace(i);
      tick();
    end
    send_trace(14);
    packet_ready_i = 1'b1;
    #1 check("t3_nodrop", 128'(lost_o), 128'h0);
    tick();
    trace_valid_i = 1'b0;
    for (int i = 11; i < 15; i++) begin
      check($sformatf("t3_head%0d", i), packet_bits_o, trace_pkt(i));
      tick();
    end
    check("t3_empty", 128'(packet_valid_o), 128'h0);

    // Round-robin between two continuously requesting software channels.
    sw_word_i[0] = 32'hAAAA_0001;
    sw_word_i[1] = 32'hBBBB_0002;
    sw_valid_i   = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 check($sformatf("sw_grant%0d", k), 128'(sw_grant_o), 128'((k % 2) ? 2'b10 : 2'b01));
      tick();
      check($sformatf("sw_bits%0d", k), packet_bits_o,
            sw_pkt(k % 2, (k % 2) ? 32'hBBBB_0002 : 32'hAAAA_0001));
      check($sformatf("sw_len%0d", k), 128'(packet_len_o), 128'd35);
    end
    sw_valid_i = 2'b00;

    // Timer: compact then full timestamp.
    tu_valid_i    = 1'b1;
    tu_fulltime_i = 1'b0;
    tu_time_i     = 40'h12_3456_789A;
    #1 check("tu_grant_c", 128'(tu_grant_o), 128'h1);
    tick();
    tu_fulltime_i = 1'b1;
    check("tu_bits_c", packet_bits_o, 128'h3C4D3);
    check("tu_len_c", 128'(packet_len_o), 128'd19);
    #1 check("tu_grant_f", 128'(tu_grant_o), 128'h1);
    tick();
    tu_valid_i = 1'b0;
    check("tu_bits_f", packet_bits_o, 128'h91_A2B3_C4D7);
    check("tu_len_f", 128'(packet_len_o), 128'd43);
    tick();
    check("tu_empty", 128'(packet_valid_o), 128'h0);

    // Trace, software and timer together: served in priority order, losers hold.
    send_trace(20);
    sw_word_i[0]  = 32'hCCCC_0003;
    sw_valid_i    = 2'b01;
    tu_valid_i    = 1'b1;
    tu_fulltime_i = 1'b0;
    tu_time_i     = 40'h00_0000_1234;
    #1 check("mx_grants0", {126'h0, sw_grant_o}, {127'h0, tu_grant_o});
    check("mx_sw0", 128'(sw_grant_o), 128'h0);
    tick();
    trace_valid_i = 1'b0;
    check("mx_trace", packet_bits_o, trace_pkt(20));
    #1 check("mx_sw1", 128'(sw_grant_o), 128'h1);
    check("mx_tu1", 128'(tu_grant_o), 128'h0);
    tick();
    sw_valid_i = 2'b00;
    check("mx_swpkt", packet_bits_o, sw_pkt(0, 32'hCCCC_0003));
    #1 check("mx_tu2", 128'(tu_grant_o), 128'h1);
    tick();
    tu_valid_i = 1'b0;
    check("mx_tupkt", packet_bits_o, 128'h91A3);
    tick();

    // Reset with drops pending: FIFO and loss count discarded.
    packet_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_trace(30 + i);
      tick();
    end
    trace_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1 check("rr_valid", 128'(packet_valid_o), 128'h0);
    #3 rst_ni = 1'b1;
    packet_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rr_noloss%0d", i), 128'(packet_valid_o), 128'h0);
    end

    // Saturation of the loss count.
    packet_ready_i = 1'b0;
    pulses = 0;
    send_trace(40);
    for (int n = 0; n < 70004; n++) begin
      #1 if (lost_o) pulses++;
      tick();
    end
    check("sat_pulses", 128'(pulses), 128'd70000);
    trace_valid_i  = 1'b0;
    packet_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("sat_bits", packet_bits_o, 128'h3FFFC);
    check("sat_len", 128'(packet_len_o), 128'd18);
    tick();
    check("sat_empty", 128'(packet_valid_o), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
